// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared move encodings, FSM states and LFSR helpers for rps_round_ctrl
package rps_pkg;

    localparam logic [2:0] MOVE_NONE     = 3'b000;
    localparam logic [2:0] MOVE_ROCK     = 3'b001;
    localparam logic [2:0] MOVE_PAPER    = 3'b010;
    localparam logic [2:0] MOVE_SCISSORS = 3'b100;

    // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3 of a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REVEAL   = 2'd1,
        HOLD     = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [2:0] lfsr_to_move(input logic [7:0] v);
        logic [7:0] r;
        r = v % 8'd3;
        case (r)
            8'd0:    return MOVE_ROCK;
            8'd1:    return MOVE_PAPER;
            default: return MOVE_SCISSORS;
        endcase
    endfunction

endpackage

// File: rtl/rps_debounce.sv
// rtl/rps_debounce.sv - 2-flop button synchronizer with optional debounce filter (RPS_DEBOUNCE_EN)
module rps_debounce #(
    parameter int unsigned W          = 3,
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] level
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // two-stage synchronizer on the raw asynchronous buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

`ifdef RPS_DEBOUNCE_EN
    // counter reaches DEB_MAX on the last required stable cycle; 0 or 1 means follow immediately
    localparam int unsigned DEB_MAX = (DEB_CYCLES > 1) ? DEB_CYCLES - 1 : 0;
    localparam int unsigned CNT_W   = (DEB_MAX > 0) ? $clog2(DEB_MAX + 1) : 1;

    logic [W-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]            level_q, level_d;

    // per bit: count consecutive cycles the synchronized value disagrees with the level
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < int'(W); i++) begin
            if (sync_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEB_MAX)) begin
                level_d[i] = sync_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // debounce counter and filtered level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync_q;
`endif

endmodule

// File: rtl/rps_round_ctrl.sv
// rtl/rps_round_ctrl.sv - rock-paper-scissors round controller; RPS_DEBOUNCE_EN enables button debounce
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 250000,
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] btn,
    output logic [2:0] user,
    output logic [2:0] compu,
    output logic       round_valid,
    output logic       busy
);

    localparam int unsigned HOLD_EFF  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam int unsigned HOLD_W    = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_EFF - 1);
    localparam logic [7:0]  SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [2:0] btn_sync;
    logic [2:0] btn_lvl;

    rps_debounce #(
        .W          (3),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk      (CLK),
        .rst      (RST),
        .din      (btn),
        .sync_out (btn_sync),
        .level    (btn_lvl)
    );

    logic [7:0]  lfsr_q, lfsr_d;
    logic [2:0]  lvl_prev_q, lvl_prev_d;
    logic        armed_q, armed_d;
    logic [1:0]  settle_q, settle_d;
    logic [2:0]  press;

    // Presses are only honoured once the buttons have been seen released after the
    // synchronizer has filled, so a button held through reset never counts as a press.
    always_comb begin
        lfsr_d     = lfsr_step(lfsr_q);
        lvl_prev_d = btn_lvl;
        settle_d   = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d    = armed_q | ((settle_q == 2'd2) && (btn_lvl == 3'b000) && (btn_sync == 3'b000));
        press      = btn_lvl & ~lvl_prev_q & {3{armed_q}};
    end

    // free-running LFSR, edge-detect history and release arming
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr_q     <= SEED_EFF;
            lvl_prev_q <= '0;
            armed_q    <= 1'b0;
            settle_q   <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            lvl_prev_q <= lvl_prev_d;
            armed_q    <= armed_d;
            settle_q   <= settle_d;
        end
    end

    state_e            state_q, state_d;
    logic [2:0]        user_q, user_d;
    logic [2:0]        compu_q, compu_d;
    logic              rv_q, rv_d;
    logic              busy_q, busy_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // round sequencing: latch a single press, reveal for one cycle, hold, wait for release
    always_comb begin
        state_d    = state_q;
        user_d     = user_q;
        compu_d    = compu_q;
        rv_d       = 1'b0;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if ($countones(press) == 1) begin
                    state_d = REVEAL;
                    user_d  = press;
                    compu_d = lfsr_to_move(lfsr_q);
                    rv_d    = 1'b1;
                end
            end
            REVEAL: begin
                state_d    = HOLD;
                hold_cnt_d = HOLD_LOAD;
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = WAIT_REL;
                    user_d  = MOVE_NONE;
                    compu_d = MOVE_NONE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            WAIT_REL: begin
                if (btn_lvl == 3'b000) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                user_d  = MOVE_NONE;
                compu_d = MOVE_NONE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM state and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            user_q     <= MOVE_NONE;
            compu_q    <= MOVE_NONE;
            rv_q       <= 1'b0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            user_q     <= user_d;
            compu_q    <= compu_d;
            rv_q       <= rv_d;
            busy_q     <= busy_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign user        = user_q;
    assign compu       = compu_q;
    assign round_valid = rv_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// tb/tb_rps_round_ctrl.sv - self-checking bench for rps_round_ctrl against a behavioural round model
module tb_rps_round_ctrl;

    localparam int         DEB      = 4;
    localparam int         HOLD     = 8;
    localparam int         HOLD_EFF = (HOLD == 0) ? 1 : HOLD;
    localparam logic [7:0] SEED     = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn = 3'b000;
    logic [2:0] user;
    logic [2:0] compu;
    logic       round_valid;
    logic       busy;

    always #5 clk = ~clk;

    rps_round_ctrl #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD),
        .LFSR_SEED   (SEED)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .btn         (btn),
        .user        (user),
        .compu       (compu),
        .round_valid (round_valid),
        .busy        (busy)
    );

    int tests = 0;
    int fails = 0;

    // model: button pipeline as delays, round as a remaining-display countdown
    logic [2:0] m_s1, m_s2, m_prev;
`ifdef RPS_DEBOUNCE_EN
    logic [2:0] m_lvl;
    int         m_run [3];
`endif
    bit         m_released;
    int         m_age;
    logic [7:0] m_lfsr;
    logic [2:0] m_user, m_compu;
    bit         m_rv, m_busy;
    int         m_show;
    int         m_rounds = 0;

    int         rv_cnt, busy_cnt, disp_cnt;
    logic [2:0] win_user, first_user, first_compu, seen_moves;
    string      phase = "reset";

    function automatic logic [7:0] next_lfsr(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] lfsr_n(input logic [7:0] v, input int n);
        logic [7:0] x;
        x = v;
        for (int i = 0; i < n; i++) x = next_lfsr(x);
        return x;
    endfunction

    function automatic logic [2:0] move_of(input logic [7:0] v);
        int r;
        r = int'(v) % 3;
        return 3'(1 << r);
    endfunction

    function automatic logic [2:0] cur_lvl();
`ifdef RPS_DEBOUNCE_EN
        return m_lvl;
`else
        return m_s2;
`endif
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_prev = 0;
`ifdef RPS_DEBOUNCE_EN
        m_lvl = 0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
`endif
        m_released = 0; m_age = 0;
        m_lfsr = (SEED == 8'h00) ? 8'h01 : SEED;
        m_user = 0; m_compu = 0; m_rv = 0; m_busy = 0; m_show = 0;
    endtask

    task automatic model_edge(input logic [2:0] b);
        logic [2:0] lv, press;
        if (rst) begin
            model_reset();
            return;
        end
        lv    = cur_lvl();
        press = lv & ~m_prev & (m_released ? 3'b111 : 3'b000);
        m_rv  = 0;
        if (m_show > 0) begin
            m_show--;
            if (m_show == 0) begin m_user = 0; m_compu = 0; end
        end else if (m_busy) begin
            if (lv == 3'b000) m_busy = 0;
        end else if ($countones(press) == 1) begin
            m_user = press; m_compu = move_of(m_lfsr);
            m_rv = 1; m_busy = 1; m_show = 1 + HOLD_EFF; m_rounds++;
        end
        if (m_age >= 2 && lv == 3'b000 && m_s2 == 3'b000) m_released = 1;
        m_prev = lv;
`ifdef RPS_DEBOUNCE_EN
        for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] >= ((DEB > 1) ? DEB : 1)) begin m_lvl[i] = m_s2[i]; m_run[i] = 0; end
            end else begin
                m_run[i] = 0;
            end
        end
`endif
        m_s2 = m_s1; m_s1 = b;
        m_lfsr = next_lfsr(m_lfsr);
        if (m_age < 2) m_age++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%s] t=%0t: got %0h expected %0h", name, phase, $time, act, exp);
        end
    endtask

    task automatic clear_win(input logic [2:0] u, input string p);
        rv_cnt = 0; busy_cnt = 0; disp_cnt = 0; win_user = u; phase = p;
        first_user = 3'b000; first_compu = 3'b000;
    endtask

    // one clock: drive, let the model take the same edge, compare all outputs
    task automatic cycle(input logic [2:0] b);
        btn = b;
        @(posedge clk);
        model_edge(b);
        #1;
        check("outputs", {24'h0, user, compu, round_valid, busy}, {24'h0, m_user, m_compu, m_rv, m_busy});
        if (round_valid) begin
            if (rv_cnt == 0) begin first_user = user; first_compu = compu; end
            rv_cnt++;
            seen_moves |= compu;
        end
        if (busy) busy_cnt++;
        if (win_user != 3'b000 && user == win_user) disp_cnt++;
    endtask

    int         start_rounds;
    int         cyc;
    int         len;
    int         period;
    logic [7:0] l;
    logic [2:0] b;

    initial begin
        model_reset();
        seen_moves = 3'b000;
        clear_win(3'b000, "reset");

        check("model_lfsr_step1", {24'h0, next_lfsr(8'hA5)}, 32'h4A);
        check("model_lfsr_step2", {24'h0, lfsr_n(8'hA5, 2)}, 32'h95);
        check("model_lfsr_step4", {24'h0, lfsr_n(8'hA5, 4)}, 32'h54);
        check("model_move_a5", {29'h0, move_of(8'hA5)}, 32'h1);
        l = SEED; period = 0;
        do begin l = next_lfsr(l); period++; end while (l != SEED && period < 300);
        check("lfsr_period", period, 255);

        repeat (3) cycle(3'b000);
        check("reset_outputs", {24'h0, user, compu, round_valid, busy}, 32'h0);
        rst = 1'b0;

        clear_win(3'b010, "basic_round");
        repeat (2) cycle(3'b000);
        repeat (10) cycle(3'b010);
        repeat (20) cycle(3'b000);
        check("basic_rv_count", rv_cnt, 1);
        check("basic_user", {29'h0, first_user}, 32'h2);
        check("basic_compu", {29'h0, first_compu}, 32'h1);
        check("basic_display_cycles", disp_cnt, 1 + HOLD);
        check("basic_idle_after", {31'h0, busy}, 32'h0);

        clear_win(3'b011, "double_press");
        repeat (10) cycle(3'b011);
        repeat (10) cycle(3'b000);
        check("double_rv_count", rv_cnt, 0);
        check("double_busy_count", busy_cnt, 0);

`ifdef RPS_DEBOUNCE_EN
        clear_win(3'b001, "glitch");
        repeat (4) begin
            repeat (2) cycle(3'b001);
            repeat (3) cycle(3'b000);
        end
        check("glitch_rv_count", rv_cnt, 0);
        clear_win(3'b001, "stable_press");
        repeat (5) cycle(3'b001);
        repeat (25) cycle(3'b000);
        check("stable_rv_count", rv_cnt, 1);
`endif

        clear_win(3'b100, "held_wait_rel");
        repeat (25) cycle(3'b100);
        check("held_busy", {31'h0, busy}, 32'h1);
        check("held_user_cleared", {29'h0, user}, 32'h0);
        repeat (10) cycle(3'b100);
        check("held_busy_late", {31'h0, busy}, 32'h1);
        repeat (12) cycle(3'b000);
        check("held_released_idle", {31'h0, busy}, 32'h0);
        check("held_rv_count", rv_cnt, 1);
        clear_win(3'b100, "re_press");
        repeat (5) cycle(3'b100);
        repeat (20) cycle(3'b000);
        check("repress_rv_count", rv_cnt, 1);
        check("repress_display", disp_cnt, 1 + HOLD);

        clear_win(3'b010, "reset_mid_hold");
        repeat (8) cycle(3'b010);
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {24'h0, user, compu, round_valid, busy}, 32'h0);
        repeat (2) cycle(3'b010);
        rst = 1'b0;
        clear_win(3'b010, "held_through_reset");
        repeat (20) cycle(3'b010);
        check("held_reset_rv_count", rv_cnt, 0);
        repeat (10) cycle(3'b000);
        clear_win(3'b010, "after_reset_press");
        repeat (6) cycle(3'b010);
        repeat (20) cycle(3'b000);
        check("after_reset_rv_count", rv_cnt, 1);

        clear_win(3'b000, "free_run");
        seen_moves   = 3'b000;
        start_rounds = m_rounds;
        cyc          = 0;
        while ((m_rounds - start_rounds) < 765 && cyc < 60000) begin
            if ($urandom_range(0, 7) == 0) b = 3'($urandom_range(0, 7));
            else                           b = 3'(1 << $urandom_range(0, 2));
            len = $urandom_range(1, 8);
            repeat (len) cycle(b);
            cyc += len;
            len = $urandom_range(1, 10);
            repeat (len) cycle(3'b000);
            cyc += len;
        end
        check("free_run_round_budget", {31'h0, ((m_rounds - start_rounds) >= 765)}, 32'h1);
        check("free_run_rv_vs_model", rv_cnt, m_rounds - start_rounds);
        check("free_run_moves_seen", {29'h0, seen_moves}, 32'h7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
